// File: rtl/router_hdr_stager.sv
// Header stager: buffers A/B request headers, pairs them onto the route
// operand bus, holds it while the decision settles, then hands the result on.

module router_hdr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         ready_o,
  output logic         nempty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;

  // Ready looks only at the count: no push-through on a full FIFO.
  assign ready_o  = !rst && (cnt_q < (AW+1)'(DEPTH));
  assign nempty_o = (cnt_q != '0);
  assign head_o   = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wp_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wp_q <= wp_q + 1'b1;
      end
      if (pop_i) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

module router_hdr_stager #(
  parameter int DEPTH        = 2,
  parameter int SETTLE_CYC   = 1,
  parameter int PAIR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [29:0] a_hdr,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [29:0] b_hdr,
  output logic [59:0] rt_in,
  input  logic [2:0]  rt_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_dec,
  output logic [1:0]  res_pad,
  output logic        busy
);

  localparam int TW = (PAIR_TIMEOUT > 0) ? $clog2(PAIR_TIMEOUT + 1) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESULT
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tcnt_q;
  logic [SW-1:0] scnt_q;
  logic [59:0]   rt_q;
  logic [1:0]    pad_q;
  logic          rv_q;
  logic [2:0]    dec_q;
  logic [1:0]    rpad_q;

  logic [29:0] a_head;
  logic [29:0] b_head;
  logic        a_ne;
  logic        b_ne;
  logic        a_push;
  logic        b_push;
  logic        a_pop;
  logic        b_pop;
  logic        ld_pair;
  logic        ld_a;
  logic        ld_b;
  logic        lone;

  assign a_push = a_valid && a_ready;
  assign b_push = b_valid && b_ready;

  router_hdr_fifo #(.DEPTH(DEPTH), .W(30)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .push_i   (a_push),
    .pop_i    (a_pop),
    .din_i    (a_hdr),
    .head_o   (a_head),
    .ready_o  (a_ready),
    .nempty_o (a_ne)
  );

  router_hdr_fifo #(.DEPTH(DEPTH), .W(30)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .push_i   (b_push),
    .pop_i    (b_pop),
    .din_i    (b_hdr),
    .head_o   (b_head),
    .ready_o  (b_ready),
    .nempty_o (b_ne)
  );

  assign lone = a_ne ^ b_ne;

  // Pairing always wins; a lone head only goes once the wait expires.
  always_comb begin
    ld_pair = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    if (state_q == IDLE) begin
      ld_pair = a_ne && b_ne;
      if (PAIR_TIMEOUT != 0 && tcnt_q == TW'(PAIR_TIMEOUT)) begin
        ld_a = a_ne && !b_ne;
        ld_b = b_ne && !a_ne;
      end
    end
    a_pop = ld_pair || ld_a;
    b_pop = ld_pair || ld_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      rt_q    <= '0;
      pad_q   <= '0;
      rv_q    <= 1'b0;
      dec_q   <= '0;
      rpad_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ld_pair || ld_a || ld_b) begin
            rt_q[29:0]  <= ld_b ? 30'd0 : a_head;
            rt_q[59:30] <= ld_a ? 30'd0 : b_head;
            pad_q       <= {ld_a, ld_b};
            tcnt_q      <= '0;
            scnt_q      <= '0;
            state_q     <= EVAL;
          end else if (lone && PAIR_TIMEOUT != 0) begin
            tcnt_q <= tcnt_q + 1'b1;
          end else begin
            tcnt_q <= '0;
          end
        end
        EVAL: begin
          tcnt_q <= '0;
          if (scnt_q == SW'(SETTLE_CYC - 1)) begin
            dec_q   <= rt_out;
            rpad_q  <= pad_q;
            rv_q    <= 1'b1;
            state_q <= RESULT;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        RESULT: begin
          tcnt_q <= '0;
          if (res_ready) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rt_in     = rt_q;
  assign res_valid = rv_q;
  assign res_dec   = dec_q;
  assign res_pad   = rpad_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_router_hdr_stager.sv
// Directed bench for router_hdr_stager: cycle table on a short-timeout
// instance plus sequences for settle latency, no-timeout and reset.

module tb_router_hdr_stager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        av0 = 0, bv0 = 0, rr0 = 0;
  logic [29:0] ah0 = '0, bh0 = '0;
  logic        ar0, br0, rv0, busy0;
  logic [59:0] rt_in0;
  logic [2:0]  rt_out0, dec0;
  logic [1:0]  pad0;

  logic        av1 = 0, bv1 = 0, rr1 = 0;
  logic [29:0] ah1 = '0, bh1 = '0;
  logic        ar1, br1, rv1, busy1;
  logic [59:0] rt_in1;
  logic [2:0]  rt_out1 = 3'b111;
  logic [2:0]  dec1;
  logic [1:0]  pad1;

  function automatic logic [2:0] fdec(input logic [59:0] r);
    return {r[59], r[1] ^ r[0], r[30]};
  endfunction

  assign rt_out0 = fdec(rt_in0);

  router_hdr_stager #(.DEPTH(2), .SETTLE_CYC(1), .PAIR_TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst),
    .a_valid(av0), .a_ready(ar0), .a_hdr(ah0),
    .b_valid(bv0), .b_ready(br0), .b_hdr(bh0),
    .rt_in(rt_in0), .rt_out(rt_out0),
    .res_valid(rv0), .res_ready(rr0), .res_dec(dec0), .res_pad(pad0),
    .busy(busy0)
  );

  router_hdr_stager #(.DEPTH(2), .SETTLE_CYC(3), .PAIR_TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst),
    .a_valid(av1), .a_ready(ar1), .a_hdr(ah1),
    .b_valid(bv1), .b_ready(br1), .b_hdr(bh1),
    .rt_in(rt_in1), .rt_out(rt_out1),
    .res_valid(rv1), .res_ready(rr1), .res_dec(dec1), .res_pad(pad1),
    .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        av;
    logic [29:0] ah;
    logic        bv;
    logic [29:0] bh;
    logic        rr;
    logic        ar;
    logic        br;
    logic        rv;
    logic [2:0]  dec;
    logic [1:0]  pad;
    logic        busy;
    logic [59:0] rt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic av, logic [29:0] ah, logic bv, logic [29:0] bh, logic rr,
    logic ar, logic br, logic rv, logic [2:0] dec, logic [1:0] pad,
    logic busy, logic [59:0] rt);
    vec_t v;
    v.av = av; v.ah = ah; v.bv = bv; v.bh = bh; v.rr = rr;
    v.ar = ar; v.br = br; v.rv = rv; v.dec = dec; v.pad = pad;
    v.busy = busy; v.rt = rt;
    return v;
  endfunction

  localparam logic [59:0] RT1 = 60'h0800_0000_4000_0003;
  localparam logic [59:0] RTP = 60'h155;
  localparam logic [59:0] RQ1 = {30'h21, 30'h11};
  localparam logic [59:0] RQ2 = {30'h22, 30'h12};
  localparam logic [59:0] RQ3 = {30'h23, 30'h13};

  initial begin
    logic seen;
    logic [29:0] ea, eb;
    int got;

    // basic pair
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 60'h0));
    tv.push_back(mk(1, 30'h3, 1, 30'h2000_0001, 1, 1, 1, 0, 0, 0, 0, 60'h0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3'b101, 2'b00, 1, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    // lone A header, padded after 4 waiting cycles
    tv.push_back(mk(1, 30'h155, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RT1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, RTP));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3'b010, 2'b10, 1, RTP));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RTP));
    // backpressure until both FIFOs fill
    tv.push_back(mk(1, 30'h11, 1, 30'h21, 0, 1, 1, 0, 0, 0, 0, RTP));
    tv.push_back(mk(1, 30'h12, 1, 30'h22, 0, 1, 1, 0, 0, 0, 1, RQ1));
    tv.push_back(mk(1, 30'h13, 1, 30'h23, 0, 0, 0, 1, 3'b011, 0, 1, RQ1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 1, RQ1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 1, RQ1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, RQ1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, RQ2));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'b010, 0, 1, RQ2));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RQ2));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, RQ3));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3'b001, 0, 1, RQ3));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, RQ3));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {62'd0, ar0, br0}, 64'd0);
    chk("rst_out0", {3'd0, rt_in0, rv0}, 64'd0);
    chk("rst_busy", {62'd0, busy0, busy1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {60'd0, ar0, br0, ar1, br1}, 64'hf);

    foreach (tv[i]) begin
      @(negedge clk);
      av0 = tv[i].av; ah0 = tv[i].ah;
      bv0 = tv[i].bv; bh0 = tv[i].bh;
      rr0 = tv[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_st", i), {60'd0, ar0, br0, rv0, busy0},
          {60'd0, tv[i].ar, tv[i].br, tv[i].rv, tv[i].busy});
      chk($sformatf("v%0d_rt", i), {4'd0, rt_in0}, {4'd0, tv[i].rt});
      if (tv[i].rv)
        chk($sformatf("v%0d_res", i), {59'd0, dec0, pad0},
            {59'd0, tv[i].dec, tv[i].pad});
    end

    // stream 10 pairs across several pointer wraps
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int g;
          @(negedge clk);
          av0 = 1; bv0 = 1;
          ah0 = 30'h100 + 30'(i);
          bh0 = 30'h200 + 30'(i);
          g = 0;
          while (!(ar0 && br0) && g < 300) begin
            @(negedge clk);
            g++;
          end
          if (g >= 300) begin
            errors++;
            $display("FAIL wrap_push%0d timeout", i);
          end
          @(posedge clk);
        end
        @(negedge clk);
        av0 = 0; bv0 = 0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 10 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          rr0 = 1'($urandom_range(0, 1));
          if (rv0 && rr0) begin
            ea = 30'h100 + 30'(got);
            eb = 30'h200 + 30'(got);
            chk($sformatf("wrap%0d_rt", got), {4'd0, rt_in0},
                {4'd0, eb, ea});
            chk($sformatf("wrap%0d_res", got), {59'd0, dec0, pad0},
                {59'd0, fdec({eb, ea}), 2'b00});
            got++;
          end
        end
        if (got < 10) begin
          errors++;
          $display("FAIL wrap_count actual=%0d required=10", got);
        end
      end
    join
    @(negedge clk);
    rr0 = 1;
    repeat (6) @(negedge clk);
    chk("wrap_nodup", {62'd0, rv0, busy0}, 64'd0);

    // PAIR_TIMEOUT=0: a lone header never loads
    @(negedge clk);
    av1 = 1; ah1 = 30'h7;
    @(negedge clk);
    av1 = 0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | busy1;
    end
    chk("pt0_noload", {63'd0, seen}, 64'd0);

    // settle latency 3 with a changing decision
    bv1 = 1; bh1 = 30'h9;
    @(negedge clk);
    bv1 = 0;
    @(posedge clk);
    #1;
    chk("s3_load", {3'd0, rt_in1, busy1}, {3'd0, 30'h9, 30'h7, 1'b1});
    rt_out1 = 3'b001;
    @(posedge clk);
    #1;
    chk("s3_c1", {63'd0, rv1}, 64'd0);
    rt_out1 = 3'b010;
    @(posedge clk);
    #1;
    chk("s3_c2", {63'd0, rv1}, 64'd0);
    rt_out1 = 3'b110;
    @(posedge clk);
    #1;
    chk("s3_res", {58'd0, rv1, dec1, pad1}, {58'd0, 1'b1, 3'b110, 2'b00});
    @(negedge clk);
    rr1 = 1;
    @(posedge clk);
    #1;
    chk("s3_drop", {63'd0, rv1}, 64'd0);

    // reset in EVAL with one header queued on each port
    rt_out1 = 3'b100;
    @(negedge clk);
    av1 = 1; bv1 = 1; ah1 = 30'h31; bh1 = 30'h32;
    @(negedge clk);
    ah1 = 30'h41; bh1 = 30'h42;
    @(posedge clk);
    #1;
    chk("mr_eval", {63'd0, busy1}, 64'd1);
    @(negedge clk);
    av1 = 0; bv1 = 0;
    rst = 1;
    @(posedge clk);
    #1;
    chk("mr_clear", {2'd0, rt_in1, rv1, busy1}, 64'd0);
    chk("mr_ready_lo", {63'd0, ar1}, 64'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mr_ready_hi", {62'd0, ar1, br1}, 64'd3);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | busy1 | rv1;
    end
    chk("mr_discard", {63'd0, seen}, 64'd0);
    av1 = 1; bv1 = 1; ah1 = 30'h51; bh1 = 30'h52;
    @(negedge clk);
    av1 = 0; bv1 = 0;
    @(posedge clk);
    #1;
    chk("mr_fresh_rt", {4'd0, rt_in1}, {4'd0, 30'h52, 30'h51});
    repeat (3) @(posedge clk);
    #1;
    chk("mr_fresh_res", {60'd0, rv1, dec1}, {60'd0, 1'b1, 3'b100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
